// File: rtl/intr_controller.sv
// Four-line maskable plus one NMI interrupt controller: edge capture, lowest-index
// priority, and a single level of NMI preemption over a maskable service.
module intr_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       nmi_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       isInterrupted,
  input  logic       INA,
  input  logic       eoi,
  output logic       INT,
  output logic       NMI,
  output logic       INTD,
  output logic [2:0] vector,
  output logic [3:0] pending
);

  localparam int unsigned NIRQ = 4;
  localparam int unsigned IW   = 2;

  typedef enum logic [1:0] {IDLE, INT_SVC, NMI_SVC, NMI_IN_INT} state_t;

  state_t          state, state_n, state_e;
  logic [NIRQ-1:0] mask, irq_q, pending_n, pend_clr, avail, irq_edge;
  logic            nmi_pend, nmi_pend_n, nmi_q, nmi_edge, nmi_clr;
  logic            isint_q, ack, armed;
  logic [IW-1:0]   saved_idx, saved_idx_n, low_idx;
  logic [2:0]      vector_n, vector_e;

  // armed stays low for the first clock after reset so lines held high
  // through reset release do not look like fresh edges
  assign irq_edge = armed ? (irq & ~irq_q) : '0;
  assign nmi_edge = armed & nmi_in & ~nmi_q;
  assign ack      = armed & isInterrupted & ~isint_q;
  assign avail    = pending & ~mask;

  assign INT  = (|avail) && (state == IDLE);
  assign NMI  = nmi_pend && (state != NMI_SVC) && (state != NMI_IN_INT);
  assign INTD = (state != IDLE);

  // lowest set bit of avail wins
  always_comb begin
    low_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (avail[i]) low_idx = IW'(i);
    end
  end

  // eoi is applied first; ack is then judged against the post-eoi state
  always_comb begin
    state_e     = state;
    vector_e    = vector;
    pend_clr    = '0;
    nmi_clr     = 1'b0;
    saved_idx_n = saved_idx;

    if (eoi) begin
      case (state)
        INT_SVC, NMI_SVC: state_e = IDLE;
        NMI_IN_INT: begin
          state_e  = INT_SVC;
          vector_e = {1'b0, saved_idx};
        end
        default: state_e = state;
      endcase
    end

    state_n  = state_e;
    vector_n = vector_e;

    if (ack) begin
      if (INA) begin
        if ((state_e == IDLE) && (|avail)) begin
          pend_clr = NIRQ'(1) << low_idx;
          vector_n = {1'b0, low_idx};
          state_n  = INT_SVC;
        end
      end else if (nmi_pend && ((state_e == IDLE) || (state_e == INT_SVC))) begin
        nmi_clr  = 1'b1;
        vector_n = 3'b100;
        if (state_e == INT_SVC) begin
          saved_idx_n = vector_e[IW-1:0];
          state_n     = NMI_IN_INT;
        end else begin
          state_n = NMI_SVC;
        end
      end
    end

    // new edges override same-cycle clears
    pending_n  = (pending & ~pend_clr) | irq_edge;
    nmi_pend_n = (nmi_pend & ~nmi_clr) | nmi_edge;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      nmi_pend  <= 1'b0;
      mask      <= '1;
      saved_idx <= '0;
      vector    <= '0;
      irq_q     <= '0;
      nmi_q     <= 1'b0;
      isint_q   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      nmi_pend  <= nmi_pend_n;
      saved_idx <= saved_idx_n;
      vector    <= vector_n;
      irq_q     <= irq;
      nmi_q     <= nmi_in;
      isint_q   <= isInterrupted;
      armed     <= 1'b1;
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
REQ-004 irq  input  4  external maskable request lines, rising-edge sensitive; bit 0 is highest priority.
REQ-005 nmi_in  input  1  external non-maskable request line, rising-edge sensitive.
REQ-006 mask_we  input  1  write strobe for the mask register.
REQ-007 mask_wdata  input  4  new mask value; bit=1 masks that irq.
REQ-008 isInterrupted  input  1  acknowledge level from the CPU controller; its 0->1 transition is the acknowledge event.
REQ-009 INA  input  1  acknowledge type, valid with isInterrupted: 1 = maskable taken, 0 = NMI taken.
REQ-010 eoi  input  1  single-cycle end-of-interrupt pulse from the handler.
REQ-011 INT  output  1  maskable interrupt request to the controller.
REQ-012 NMI  output  1  non-maskable interrupt request to the controller.
REQ-013 INTD  output  1  interrupt-disable to the controller; high while any service is active.
REQ-014 vector  output  3  {nmi, idx[1:0]} of the interrupt being serviced.
REQ-015 pending  output  4  maskable pending register, for status read.

Function
REQ-016 Edge detect SHALL use a registered copy of irq and nmi_in; a bit is an edge when its current value is 1 and its registered value is 0.
REQ-017 An irq edge SHALL set pending[i] on the next clock edge, regardless of the mask.
REQ-018 An nmi_in edge SHALL set nmi_pend on the next clock edge.
REQ-019 The acknowledge event (ack) SHALL be isInterrupted=1 with isInterrupted_q=0, sampled on the clock edge.
REQ-020 States SHALL be IDLE, INT_SVC, NMI_SVC, NMI_IN_INT.
REQ-021 INT SHALL equal |(pending & ~mask) AND state==IDLE (combinational).
REQ-022 NMI SHALL equal nmi_pend AND state!=NMI_SVC AND state!=NMI_IN_INT, so NMIs are not reentrant.
REQ-023 INTD SHALL be 1 exactly when state!=IDLE.
REQ-024 IDLE, ack with INA=1 and INT=1: select the lowest unmasked pending index k, then clear pending[k], set vector to {0,k}, and move to INT_SVC.
REQ-025 ack with INA=0 and nmi_pend=1:
- clear nmi_pend and set vector to 100;
- from IDLE, move to NMI_SVC;
- from INT_SVC, save vector[1:0] to saved_idx and move to NMI_IN_INT.
REQ-026 ack with INA=1 and INT=0, or ack with INA=0 and nmi_pend=0, SHALL be ignored; state is unchanged.
REQ-027 eoi SHALL have these effects:
- INT_SVC -> IDLE;
- NMI_SVC -> IDLE;
- NMI_IN_INT -> INT_SVC, with vector restored to {0,saved_idx};
- IDLE: no effect.
REQ-028 While idle, vector SHALL hold its last value.
REQ-029 Same-cycle clear (REQ-024) and new edge on the same pending bit: set SHALL win, so the bit stays 1.
REQ-030 mask_we SHALL update the mask on the next edge; an ack in the same cycle SHALL use the old mask.
REQ-031 Same-cycle ack and eoi: eoi SHALL be applied first, then ack is evaluated against the resulting state.
REQ-032 An nmi_in edge in the same cycle as an NMI ack clearing nmi_pend SHALL leave nmi_pend=1.
REQ-033 Masked pending bits SHALL be retained and become eligible when unmasked.

Reset
REQ-034 On reset the block SHALL set:
- state=IDLE;
- pending=0000, nmi_pend=0, mask=1111, saved_idx=00;
- vector=000, INT=0, NMI=0, INTD=0;
- edge registers = 0, isInterrupted_q=0.
REQ-035 A reset asserted mid-service SHALL abandon the service immediately, with no eoi required.
REQ-036 A line held high through reset release SHALL NOT register as an edge.

Verification
REQ-037 Priority: mask=0000, irq edges on bits 3 and 1 in the same cycle, ack INA=1 -> vector=001, pending=1000, INTD=1, INT=0; after eoi -> INT=1 again.
REQ-038 Masking: mask=1111, irq[2] edge -> pending=0100, INT=0; write mask=1011 -> INT=1 next cycle.
REQ-039 NMI preemption:
- in INT_SVC with vector=010, nmi_in edge -> NMI=1;
- ack INA=0 -> vector=100, state NMI_IN_INT, NMI=0;
- eoi -> vector=010, state INT_SVC;
- eoi -> IDLE, INTD=0.
REQ-040 NMI non-reentrant: in NMI_SVC, second nmi_in edge -> nmi_pend=1, NMI=0; eoi -> NMI=1.
REQ-041 Set-wins: pending[0]=1, ack clears bit 0 in the same cycle as a new irq[0] edge -> pending[0]=1 after the edge.
REQ-042 Reset mid-operation: in NMI_IN_INT, assert reset -> all outputs 0 immediately and mask=1111.
